// File: rtl/multicycle_addsub_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor: FSM states and
// index-width sizing helper.
package multicycle_addsub_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Index counter width for n slices; a counter is never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multicycle_addsub_chunk_adder.sv
// Combinational CHUNK-bit ripple slice of full-adder cells. Also reports the
// carry entering its MSB so the top can derive signed overflow.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/multicycle_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice reused over
// WIDTH/CHUNK cycles, with start/busy/done handshake.
//
// Handshake: start is sampled only while busy=0 (state IDLE), including the
// done cycle; operands are captured on that accept edge. busy is high from the
// accept edge until the completing edge; done pulses for one cycle afterwards,
// at which point sum/carry/overflow are valid and hold until the next completion.
module multicycle_addsub
  import multicycle_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);

  state_t           state, state_next;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_next;
  logic             carry_reg;
  logic [CHUNK-1:0] slice_a, slice_b, slice_s;
  logic             slice_cout, slice_cmsb;
  logic             accept, last;

  assign accept  = (state == ST_IDLE) && start;
  assign last    = (idx == IW'(NCHUNK - 1));
  assign slice_a = a_reg[int'(idx) * CHUNK +: CHUNK];
  assign slice_b = b_reg[int'(idx) * CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a        (slice_a),
    .b        (slice_b),
    .cin      (carry_reg),
    .s        (slice_s),
    .cout     (slice_cout),
    .c_msb_in (slice_cmsb)
  );

  // Result with the current slice merged in; on the last slice this is the final sum.
  always_comb begin
    res_next = res_reg;
    res_next[int'(idx) * CHUNK +: CHUNK] = slice_s;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last)  state_next = ST_IDLE;
      default:            state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ST_RUN);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Subtraction is a + ~b + 1: invert b here and force the initial carry.
        a_reg     <= a;
        b_reg     <= b ^ {WIDTH{sub}};
        carry_reg <= sub ? 1'b1 : cin;
        idx       <= '0;
      end else if (state == ST_RUN) begin
        res_reg   <= res_next;
        carry_reg <= slice_cout;
        idx       <= idx + IW'(1);
        if (last) begin
          sum      <= res_next;
          carry    <= slice_cout;
          overflow <= slice_cout ^ slice_cmsb;
          done     <= 1'b1;
          idx      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_addsub.sv
// Self-checking bench for multicycle_addsub: a 16/4 build and a 16/16 build,
// table vectors, handshake corner sequences and randomized ops vs a model.
module tb_multicycle_addsub;
  import multicycle_addsub_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, start16, sub, cin;
  logic [15:0] a, b;
  logic [15:0] sum, sum16;
  logic        carry, overflow, busy, done;
  logic        carry16, overflow16, busy16, done16;
  state_t      dbg_state, dbg_state16;

  int checks   = 0;
  int failures = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .sum(sum), .carry(carry), .overflow(overflow), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  multicycle_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .sub(sub), .cin(cin), .a(a), .b(b),
    .sum(sum16), .carry(carry16), .overflow(overflow16), .busy(busy16), .done(done16),
    .dbg_state(dbg_state16)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Reference: integer arithmetic and signed range tests, packed as {ovf, carry, sum}.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic msub, input logic mcin);
    int sa, sb, sres;
    int unsigned ures;
    logic c;
    logic v;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      ures = (32'(ma) - 32'(mb)) & 32'hFFFF;
      c    = (ma >= mb);
      sres = sa - sb;
    end else begin
      ures = 32'(ma) + 32'(mb) + 32'(mcin);
      c    = (ures > 32'hFFFF);
      sres = sa + sb + int'(mcin);
    end
    v = (sres > 32767) || (sres < -32768);
    return {v, c, ures[15:0]};
  endfunction

  task automatic run_op(input bit use16, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tsub, input logic tcin, input string nm);
    int lat;
    logic [17:0] e;
    exp_q.push_back(model(ta, tb_v, tsub, tcin));
    @(negedge clk);
    a = ta; b = tb_v; sub = tsub; cin = tcin;
    if (use16) start16 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start16 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (use16 ? done16 : done) begin
        lat = k;
        break;
      end
    end
    check({nm, " latency"}, lat, use16 ? 1 : 4);
    e = exp_q.pop_front();
    if (lat != 0) begin
      check({nm, " sum"},   use16 ? sum16 : sum,           e[15:0]);
      check({nm, " carry"}, use16 ? carry16 : carry,       e[16]);
      check({nm, " ovf"},   use16 ? overflow16 : overflow, e[17]);
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   cnt, first, lat;
    logic [15:0] ra, rb;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; start16 = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset sum", sum, 16'h0);
    check("reset carry", carry, 1'b0);
    check("reset ovf", overflow, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset state", dbg_state, ST_IDLE);

    // Table vectors: the model must agree with hand-derived constants, then the DUT with the model.
    foreach (vecs[i]) begin
      check($sformatf("vec%0d model", i), model(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin),
            {vecs[i].ovf, vecs[i].carry, vecs[i].sum});
      run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, $sformatf("vec%0d", i));
    end

    // Start while busy is ignored; operand changes mid-run have no effect.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy after accept", busy, 1'b1);
    check("state after accept", dbg_state, ST_RUN);
    cnt = 0; first = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        if (first == 0) first = k;
      end
      if (k == 1) begin start = 1'b1; a = 16'hFFFF; end
      if (k == 2) begin start = 1'b0; a = 16'h1234; b = 16'h4321; end
    end
    check("ignore start done count", cnt, 1);
    check("ignore start latency", first, 4);
    check("ignore start sum", sum, 16'h0002);
    check("ignore start carry", carry, 1'b0);

    // Back-to-back: start raised in the done cycle is accepted.
    @(negedge clk);
    a = 16'h0100; b = 16'h0023; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin first = k; break; end
    end
    check("b2b first latency", first, 4);
    check("b2b first sum", sum, 16'h0123);
    check("b2b busy in done cycle", busy, 1'b0);
    a = 16'hFFF0; b = 16'h0020; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b second accepted", busy, 1'b1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    // Done-to-done spacing is this accept latency plus the done cycle itself.
    check("b2b second latency", lat, 4);
    check("b2b second sum", sum, 16'hFFD0);
    check("b2b second carry", carry, 1'b1);

    // Reset during RUN aborts and clears every output.
    @(negedge clk);
    a = 16'h4000; b = 16'h4000; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) cnt++;
      if (k == 2) reset = 1'b1;
      if (k == 3) begin
        reset = 1'b0;
        check("abort sum", sum, 16'h0);
        check("abort carry", carry, 1'b0);
        check("abort ovf", overflow, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
      end
    end
    check("abort no done", cnt, 0);
    run_op(1'b0, 16'h4000, 16'h4000, 1'b0, 1'b0, "after abort");

    // Single-slice build finishes one cycle after accept.
    run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "w16 wrap");
    run_op(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0, "w16 sub ovf");

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = 16'($urandom_range(0, 16'hFFFF));
      if (i % 8 == 0) ra = 16'h7FFF;
      if (i % 8 == 1) rb = 16'h8000;
      run_op(i % 4 == 3, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
